// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in the EX stage.
// Returns {remainder, quotient} after DATA_W iterations.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rem, rem_n;
    logic [DATA_W-1:0]   dvd, dvd_n;
    logic [DATA_W-1:0]   dvs, dvs_n;
    logic [DATA_W-1:0]   quo, quo_n;
    logic                neg_dvd, neg_dvd_n;
    logic                neg_dvs, neg_dvs_n;
    logic [2*DATA_W-1:0] result_n;
    logic                ready_n;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                op1_neg;
    logic                op2_neg;

    // Trial subtraction and sign-corrected final values.
    always_comb begin
        shifted = {rem, dvd[DATA_W-1]};
        diff    = shifted - {1'b0, dvs};
        quo_fix = (neg_dvd ^ neg_dvs) ? (~quo + 1'b1) : quo;
        rem_fix = neg_dvd ? (~rem + 1'b1) : rem;
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    end

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem;
        dvd_n     = dvd;
        dvs_n     = dvs;
        quo_n     = quo;
        neg_dvd_n = neg_dvd;
        neg_dvs_n = neg_dvs;
        result_n  = result_o;
        ready_n   = ready_o;
        unique case (state)
            FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n   = ON;
                        cnt_n     = '0;
                        rem_n     = '0;
                        quo_n     = '0;
                        neg_dvd_n = op1_neg;
                        neg_dvs_n = op2_neg;
                        dvd_n     = op1_neg ? (~opdata1_i + 1'b1)
                                            : opdata1_i;
                        dvs_n     = op2_neg ? (~opdata2_i + 1'b1)
                                            : opdata2_i;
                    end
                end
            end
            BYZERO: begin
                result_n = '0;
                if (annul_i) begin
                    state_n = FREE;
                    ready_n = 1'b0;
                end else begin
                    state_n = END;
                    ready_n = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n  = FREE;
                    cnt_n    = '0;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else if (cnt == LAST) begin
                    state_n  = END;
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                end else begin
                    dvd_n = {dvd[DATA_W-2:0], 1'b0};
                    cnt_n = cnt + CNT_W'(1);
                    if (!diff[DATA_W]) begin
                        rem_n = diff[DATA_W-1:0];
                        quo_n = {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_n = shifted[DATA_W-1:0];
                        quo_n = {quo[DATA_W-2:0], 1'b0};
                    end
                end
            end
            END: begin
                if (!start_i) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: begin
                state_n  = FREE;
                result_n = '0;
                ready_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            quo      <= '0;
            neg_dvd  <= 1'b0;
            neg_dvs  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            dvd      <= dvd_n;
            dvs      <= dvs_n;
            quo      <= quo_n;
            neg_dvd  <= neg_dvd_n;
            neg_dvs  <= neg_dvs_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Table vectors, corner sequences and random divides.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (opdata1),
        .opdata2_i   (opdata2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic, truncating division.
    function automatic logic [63:0] ref_div(
        input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full handshake: start, wait for ready, hold, release.
    task automatic run_div(input string tag,
                           input logic sgn,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [63:0] exp_res,
                           input int exp_lat,
                           input int toggle_at);
        int n;
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        annul = 1'b0;
        start = 1'b1;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
            if (n == toggle_at) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
                signed_div = ~sgn;
            end
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        @(posedge clk);
        #1;
        check({tag, " hold"}, {ready, result}, {1'b1, exp_res});
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " release"}, {ready, result}, 65'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        logic        saw_ready;
        int          mode;

        vecs[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                    64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE,
                    64'h00000001_FFFFFFFD, 34};
        vecs[3] = '{1'b0, 32'd1234, 32'd0, 64'd0, 2};
        vecs[4] = '{1'b1, 32'h80000000, 32'd0, 64'd0, 2};
        vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                    64'h00000000_80000000, 34};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1,
                    64'h00000000_FFFFFFFF, 34};
        vecs[7] = '{1'b0, 32'd5, 32'hFFFFFFFF,
                    64'h00000005_00000000, 34};
        vecs[8] = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                    64'h80000000_00000000, 34};
        vecs[9] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                    64'hFFFFFFFE_0000000E, 34};

        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        opdata1 = '0;
        opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {ready, result}, 65'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle state", {ready, result}, 65'd0);

        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a,
                    vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat, 0);
        end

        // Annul at iteration 10, then an immediate 9/3.
        signed_div = 1'b0;
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        start = 1'b1;
        saw_ready = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
            saw_ready |= ready;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        saw_ready |= ready;
        annul = 1'b0;
        check("annul no ready", 64'(saw_ready), 64'd0);
        run_div("after annul", 1'b0, 32'd9, 32'd3,
                64'h00000000_00000003, 34, 0);

        // Annul and start together in FREE are rejected.
        signed_div = 1'b0;
        opdata1 = 32'd8;
        opdata2 = 32'd0;
        annul = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("start+annul", {ready, result}, 65'd0);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        // Operand inputs toggled mid-divide.
        run_div("toggle", 1'b0, 32'd123456789, 32'd1234,
                ref_div(1'b0, 32'd123456789, 32'd1234), 34, 3);

        // Reset at iteration 20, start held through reset.
        signed_div = 1'b0;
        opdata1 = 32'd50000;
        opdata2 = 32'd7;
        start = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset", {ready, result}, 65'd0);
        rst = 1'b0;
        run_div("after reset", 1'b0, 32'd50000, 32'd7,
                ref_div(1'b0, 32'd50000, 32'd7), 34, 0);

        // Reset while in END clears the held result.
        signed_div = 1'b0;
        opdata1 = 32'd77;
        opdata2 = 32'd0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("byzero ready", 64'(ready), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("end reset", {ready, result}, 65'd0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        // Random divides against the reference model.
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) b = 32'd0;
            else if (mode <= 2) b = 32'($urandom_range(1, 15));
            else b = $urandom;
            if (mode == 2) b = ~b + 32'd1;
            run_div($sformatf("rand%0d", i), sgn, a, b,
                    ref_div(sgn, a, b), (b == 32'd0) ? 2 : 34, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
